// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer between CPU datapath and a variable-latency word bus
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic [31:0]   a_addr;
    logic [1:0]    a_size;
    logic          a_signed;
    logic [31:0]   a_wdata;
    logic          a_we;
    logic          err_flag;
    logic          to_flag;
    logic [31:0]   rdata_q;

    logic          misaligned;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ext_c;

    // Alignment check on the live request, evaluated only at acceptance
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b00:   misaligned = |addr[1:0];
            2'b10:   misaligned = addr[0];
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data from the latched request
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = a_wdata;
        case (a_size)
            2'b01: begin
                be_c    = 4'b0001 << a_addr[1:0];
                wdata_c = {4{a_wdata[7:0]}};
            end
            2'b10: begin
                be_c    = a_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{a_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = a_wdata;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned bus word
    always_comb begin
        lane_b = bus_rdata[7:0];
        case (a_addr[1:0])
            2'd0:    lane_b = bus_rdata[7:0];
            2'd1:    lane_b = bus_rdata[15:8];
            2'd2:    lane_b = bus_rdata[23:16];
            default: lane_b = bus_rdata[31:24];
        endcase
        lane_h = a_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (a_size)
            2'b01:   ext_c = {{24{a_signed & lane_b[7]}}, lane_b};
            2'b10:   ext_c = {{16{a_signed & lane_h[15]}}, lane_h};
            default: ext_c = bus_rdata;
        endcase
    end

    // Main sequencer: accept in IDLE, wait for ack or timeout in REQ, pulse in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            cnt      <= '0;
            a_addr   <= '0;
            a_size   <= '0;
            a_signed <= 1'b0;
            a_wdata  <= '0;
            a_we     <= 1'b0;
            err_flag <= 1'b0;
            to_flag  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        a_addr   <= addr;
                        a_size   <= size;
                        a_signed <= load_signed;
                        a_wdata  <= wdata;
                        a_we     <= mem_write;
                        cnt      <= '0;
                        rdata_q  <= '0;
                        to_flag  <= 1'b0;
                        err_flag <= misaligned;
                        st       <= misaligned ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        rdata_q <= a_we ? 32'd0 : ext_c;
                        st      <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        to_flag <= 1'b1;
                        st      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err_flag <= 1'b0;
                    to_flag  <= 1'b0;
                    st       <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Outputs derived from state and latched request only (stall excepted)
    always_comb begin
        stall     = (mem_read | mem_write) & (st != DONE) & ~reset;
        done      = (st == DONE);
        align_err = done & err_flag;
        timeout   = done & to_flag;
        rdata     = done ? rdata_q : 32'd0;
        bus_req   = (st == REQ);
        bus_we    = bus_req & a_we;
        bus_addr  = bus_req ? {a_addr[31:2], 2'b00} : 32'd0;
        bus_be    = bus_req ? be_c : 4'b0000;
        bus_wdata = bus_req ? wdata_c : 32'd0;
    end

endmodule
